// File: rtl/ibex_pkg.sv
// Shared ibex types used by the iterative multiply/divide unit.
package ibex_pkg;

    // Multiply/divide operation selector.
    typedef enum logic [1:0] {
        MD_OP_MULL = 2'b00,
        MD_OP_MULH = 2'b01,
        MD_OP_DIV  = 2'b10,
        MD_OP_REM  = 2'b11
    } md_op_e;

    // Control states of the iterative multiply/divide unit.
    typedef enum logic [2:0] {
        MD_ITER_IDLE = 3'd0,
        MD_ITER_PREP = 3'd1,
        MD_ITER_ITER = 3'd2,
        MD_ITER_FIX  = 3'd3,
        MD_ITER_DONE = 3'd4
    } md_iter_state_e;

    // True for the operations that run the restoring divider.
    function automatic logic md_is_div(md_op_e op);
        return (op == MD_OP_DIV) || (op == MD_OP_REM);
    endfunction

endpackage

// File: rtl/ibex_multdiv_iter_if.sv
// Request/response handshake bundle of the iterative multiply/divide unit.
interface ibex_multdiv_iter_if #(
    parameter int Width = 32
);
    import ibex_pkg::*;

    logic             req_valid_i;
    logic             req_ready_o;
    md_op_e           operator_i;
    logic [1:0]       signed_mode_i;
    logic [Width-1:0] op_a_i;
    logic [Width-1:0] op_b_i;
    logic             data_ind_timing_i;
    logic             flush_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [Width-1:0] rsp_result_o;
    logic             busy_o;

    // The unit itself.
    modport slave (
        input  req_valid_i, operator_i, signed_mode_i, op_a_i, op_b_i,
        input  data_ind_timing_i, flush_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_result_o, busy_o
    );

    // The requester / result consumer.
    modport master (
        output req_valid_i, operator_i, signed_mode_i, op_a_i, op_b_i,
        output data_ind_timing_i, flush_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_result_o, busy_o
    );

endinterface

// File: rtl/ibex_multdiv_iter_chk.sv
// Parameter legality and handshake properties of the multiply/divide unit.
module ibex_multdiv_iter_chk #(
    parameter int Width        = 32,
    parameter int BitsPerCycle = 1
) (
    input logic             clk_i,
    input logic             rst_ni,
    input logic             i_rsp_valid,
    input logic             i_rsp_ready,
    input logic             i_req_ready,
    input logic [Width-1:0] i_rsp_result
);

    if (!((BitsPerCycle == 1) || (BitsPerCycle == 2) || (BitsPerCycle == 4)) ||
        ((Width % BitsPerCycle) != 0) || ((Width % 2) != 0) || (Width < 8)) begin : g_bad_params
        $error("ibex_multdiv_iter: illegal Width/BitsPerCycle combination");
    end

    a_result_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (i_rsp_valid && !i_rsp_ready) |=> $stable(i_rsp_result));

    a_ready_not_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        i_req_ready |-> !i_rsp_valid);

endmodule

// File: rtl/ibex_multdiv_iter_step.sv
// One radix-2 step: shift-add (multiply, LSB-first on the multiplier in i_lo)
// or compare-subtract-shift (restoring divide, dividend/quotient in i_lo).
module ibex_multdiv_iter_step #(
    parameter int Width = 32
) (
    input  logic             i_div,
    input  logic [Width:0]   i_hi,
    input  logic [Width-1:0] i_lo,
    input  logic [Width-1:0] i_opnd,
    output logic [Width:0]   o_hi,
    output logic [Width-1:0] o_lo
);

    logic [Width:0]   w_sum;
    logic [Width:0]   w_shift;
    logic [Width+1:0] w_diff;
    logic             w_borrow;

    // Multiply: bit 0 of the multiplier decides whether the multiplicand is added.
    assign w_sum    = i_hi + (i_lo[0] ? {1'b0, i_opnd} : {(Width+1){1'b0}});
    // Divide: partial remainder picks up the next dividend bit, then trial-subtract.
    assign w_shift  = {i_hi[Width-1:0], i_lo[Width-1]};
    assign w_diff   = {1'b0, w_shift} - {2'b00, i_opnd};
    assign w_borrow = w_diff[Width+1];

    // Select the step result for the active mode.
    always_comb begin
        if (i_div) begin
            o_hi = w_borrow ? w_shift : w_diff[Width:0];
            o_lo = {i_lo[Width-2:0], ~w_borrow};
        end else begin
            o_hi = {1'b0, w_sum[Width:1]};
            o_lo = {w_sum[0], i_lo[Width-1:1]};
        end
    end

endmodule

// File: rtl/ibex_multdiv_iter.sv
// Iterative multiply/divide unit with its own adder chain and state.
// Retires BitsPerCycle product/quotient bits per cycle over a Width datapath.
module ibex_multdiv_iter
    import ibex_pkg::*;
#(
    parameter int Width        = 32,
    parameter int BitsPerCycle = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    ibex_multdiv_iter_if.slave md_if
);

    localparam int NumIter = Width / BitsPerCycle;
    localparam int CntW    = $clog2(NumIter);
    localparam logic [CntW-1:0] CntInit = CntW'(NumIter - 1);

    md_iter_state_e     r_state;
    md_op_e             r_op;
    logic [1:0]         r_signed;
    logic               r_dit;
    logic [Width:0]     r_hi;
    logic [Width-1:0]   r_lo;
    logic [Width-1:0]   r_opnd;
    logic [CntW-1:0]    r_cnt;
    logic               r_res_neg;
    logic               r_b_zero;
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic               r_busy;
    logic [Width-1:0]   r_result;

    logic               w_a_neg, w_b_neg, w_is_div, w_b_zero, w_res_neg;
    logic [Width-1:0]   w_a_abs, w_b_abs;
    logic [2*Width-1:0] w_prod, w_prod_fix;
    logic [Width-1:0]   w_quo_fix, w_rem_fix, w_fix_result;

    // In PREP r_lo/r_opnd still hold the raw latched op_a/op_b.
    assign w_a_neg   = r_signed[0] & r_lo[Width-1];
    assign w_b_neg   = r_signed[1] & r_opnd[Width-1];
    assign w_a_abs   = w_a_neg ? -r_lo : r_lo;
    assign w_b_abs   = w_b_neg ? -r_opnd : r_opnd;
    assign w_is_div  = md_is_div(r_op);
    assign w_b_zero  = (r_opnd == {Width{1'b0}});
    assign w_res_neg = (r_op == MD_OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

    for (genvar g = 0; g < BitsPerCycle; g++) begin : g_step
        logic [Width:0]   w_hi_in, w_hi_out;
        logic [Width-1:0] w_lo_in, w_lo_out;
        if (g == 0) begin : g_first
            assign w_hi_in = r_hi;
            assign w_lo_in = r_lo;
        end else begin : g_next
            assign w_hi_in = g_step[g-1].w_hi_out;
            assign w_lo_in = g_step[g-1].w_lo_out;
        end
        ibex_multdiv_iter_step #(.Width(Width)) u_step (
            .i_div  (w_is_div),
            .i_hi   (w_hi_in),
            .i_lo   (w_lo_in),
            .i_opnd (r_opnd),
            .o_hi   (w_hi_out),
            .o_lo   (w_lo_out)
        );
    end

    // After iterating: product = {hi,lo}; divide leaves quotient in lo, remainder in hi.
    assign w_prod     = {r_hi[Width-1:0], r_lo};
    assign w_prod_fix = r_res_neg ? -w_prod : w_prod;
    assign w_quo_fix  = r_res_neg ? -r_lo : r_lo;
    assign w_rem_fix  = r_res_neg ? -r_hi[Width-1:0] : r_hi[Width-1:0];

    // Final sign correction and half/quotient/remainder selection.
    always_comb begin
        w_fix_result = {Width{1'b0}};
        case (r_op)
            MD_OP_MULL: w_fix_result = w_prod_fix[Width-1:0];
            MD_OP_MULH: w_fix_result = w_prod_fix[2*Width-1:Width];
            MD_OP_DIV:  w_fix_result = r_b_zero ? {Width{1'b1}} : w_quo_fix;
            MD_OP_REM:  w_fix_result = w_rem_fix;
            default:    w_fix_result = {Width{1'b0}};
        endcase
    end

    // Control FSM, datapath registers and registered handshake outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= MD_ITER_IDLE;
            r_op        <= MD_OP_MULL;
            r_signed    <= 2'b00;
            r_dit       <= 1'b0;
            r_hi        <= {(Width+1){1'b0}};
            r_lo        <= {Width{1'b0}};
            r_opnd      <= {Width{1'b0}};
            r_cnt       <= {CntW{1'b0}};
            r_res_neg   <= 1'b0;
            r_b_zero    <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_result    <= {Width{1'b0}};
        end else if ((r_state != MD_ITER_IDLE) && md_if.flush_i) begin
            r_state     <= MD_ITER_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                MD_ITER_IDLE: begin
                    if (md_if.req_valid_i) begin
                        r_op        <= md_if.operator_i;
                        r_signed    <= md_if.signed_mode_i;
                        r_dit       <= md_if.data_ind_timing_i;
                        r_lo        <= md_if.op_a_i;
                        r_opnd      <= md_if.op_b_i;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= MD_ITER_PREP;
                    end else begin
                        r_state     <= MD_ITER_IDLE;
                    end
                end
                MD_ITER_PREP: begin
                    r_hi      <= {(Width+1){1'b0}};
                    r_cnt     <= CntInit;
                    r_res_neg <= w_res_neg;
                    r_b_zero  <= w_b_zero;
                    if (w_is_div) begin
                        r_lo   <= w_a_abs;
                        r_opnd <= w_b_abs;
                    end else begin
                        r_lo   <= w_b_abs;
                        r_opnd <= w_a_abs;
                    end
                    if (w_is_div && w_b_zero && !r_dit) begin
                        r_result    <= (r_op == MD_OP_DIV) ? {Width{1'b1}} : r_lo;
                        r_rsp_valid <= 1'b1;
                        r_state     <= MD_ITER_DONE;
                    end else begin
                        r_state     <= MD_ITER_ITER;
                    end
                end
                MD_ITER_ITER: begin
                    r_hi <= g_step[BitsPerCycle-1].w_hi_out;
                    r_lo <= g_step[BitsPerCycle-1].w_lo_out;
                    if (r_cnt == {CntW{1'b0}}) begin
                        r_state <= MD_ITER_FIX;
                    end else begin
                        r_cnt   <= r_cnt - CntW'(1);
                    end
                end
                MD_ITER_FIX: begin
                    r_result    <= w_fix_result;
                    r_rsp_valid <= 1'b1;
                    r_state     <= MD_ITER_DONE;
                end
                MD_ITER_DONE: begin
                    if (md_if.rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= MD_ITER_IDLE;
                    end else begin
                        r_state     <= MD_ITER_DONE;
                    end
                end
                default: begin
                    r_state     <= MD_ITER_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign md_if.req_ready_o  = r_req_ready;
    assign md_if.rsp_valid_o  = r_rsp_valid;
    assign md_if.rsp_result_o = r_result;
    assign md_if.busy_o       = r_busy;

    ibex_multdiv_iter_chk #(.Width(Width), .BitsPerCycle(BitsPerCycle)) u_chk (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .i_rsp_valid  (r_rsp_valid),
        .i_rsp_ready  (md_if.rsp_ready_i),
        .i_req_ready  (r_req_ready),
        .i_rsp_result (r_result)
    );

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Directed bench for ibex_multdiv_iter: a Width32/B1 and a Width16/B4 instance.
module tb_ibex_multdiv_iter;
    import ibex_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    ibex_multdiv_iter_if #(.Width(32)) bus32 ();
    ibex_multdiv_iter_if #(.Width(16)) bus16 ();

    ibex_multdiv_iter #(.Width(32), .BitsPerCycle(1)) u_dut32 (
        .clk_i (clk), .rst_ni (rst_n), .md_if (bus32)
    );
    ibex_multdiv_iter #(.Width(16), .BitsPerCycle(4)) u_dut16 (
        .clk_i (clk), .rst_ni (rst_n), .md_if (bus16)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble the inputs after accept, wait for and take the response.
    task automatic run32(input md_op_e op, input logic [1:0] sm, input logic [31:0] a,
                         input logic [31:0] b, input logic dit,
                         output logic [31:0] res, output int lat);
        @(negedge clk);
        bus32.req_valid_i = 1'b1; bus32.operator_i = op; bus32.signed_mode_i = sm;
        bus32.op_a_i = a; bus32.op_b_i = b; bus32.data_ind_timing_i = dit;
        @(negedge clk);
        bus32.req_valid_i = 1'b0; bus32.op_a_i = ~a; bus32.op_b_i = ~b;
        bus32.signed_mode_i = ~sm; bus32.data_ind_timing_i = ~dit;
        lat = 1;
        while (!bus32.rsp_valid_o && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        res = bus32.rsp_result_o;
        bus32.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus32.rsp_ready_i = 1'b0;
    endtask

    task automatic run16(input md_op_e op, input logic [1:0] sm, input logic [15:0] a,
                         input logic [15:0] b, input logic dit, input logic fl,
                         output logic [15:0] res, output int lat);
        @(negedge clk);
        bus16.req_valid_i = 1'b1; bus16.operator_i = op; bus16.signed_mode_i = sm;
        bus16.op_a_i = a; bus16.op_b_i = b; bus16.data_ind_timing_i = dit; bus16.flush_i = fl;
        @(negedge clk);
        bus16.req_valid_i = 1'b0; bus16.flush_i = 1'b0; bus16.op_a_i = ~a; bus16.op_b_i = ~b;
        lat = 1;
        while (!bus16.rsp_valid_o && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = bus16.rsp_result_o;
        bus16.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus16.rsp_ready_i = 1'b0;
    endtask

    // Reference model: plain integer arithmetic on sign-extended operands.
    function automatic logic [15:0] ref16(input md_op_e op, input logic [1:0] sm,
                                          input logic [15:0] a, input logic [15:0] b);
        longint sa, sb, p;
        sa = sm[0] ? {{48{a[15]}}, a} : {48'd0, a};
        sb = sm[1] ? {{48{b[15]}}, b} : {48'd0, b};
        p  = 64'sd0;
        case (op)
            MD_OP_MULL: begin p = sa * sb; return p[15:0]; end
            MD_OP_MULH: begin p = sa * sb; return p[31:16]; end
            MD_OP_DIV:  begin
                if (b == 16'h0000) return 16'hFFFF;
                p = sa / sb; return p[15:0];
            end
            MD_OP_REM:  begin
                if (b == 16'h0000) return a;
                p = sa % sb; return p[15:0];
            end
            default: return 16'h0000;
        endcase
    endfunction

    initial begin
        logic [31:0] r32;
        logic [15:0] r16, a16, b16;
        logic [1:0]  sm;
        logic        dit;
        md_op_e      op;
        int          lat, seen, exp_lat;

        bus32.req_valid_i = 1'b0; bus32.operator_i = MD_OP_MULL; bus32.signed_mode_i = 2'b00;
        bus32.op_a_i = 32'd0; bus32.op_b_i = 32'd0; bus32.data_ind_timing_i = 1'b0;
        bus32.flush_i = 1'b0; bus32.rsp_ready_i = 1'b0;
        bus16.req_valid_i = 1'b0; bus16.operator_i = MD_OP_MULL; bus16.signed_mode_i = 2'b00;
        bus16.op_a_i = 16'd0; bus16.op_b_i = 16'd0; bus16.data_ind_timing_i = 1'b0;
        bus16.flush_i = 1'b0; bus16.rsp_ready_i = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_req_ready", 32'(bus32.req_ready_o), 32'd1);
        check("rst_rsp_valid", 32'(bus32.rsp_valid_o), 32'd0);
        check("rst_result",    bus32.rsp_result_o,     32'd0);
        check("rst_busy",      32'(bus32.busy_o),      32'd0);

        // Width 32, one bit per cycle
        run32(MD_OP_MULL, 2'b11, 32'd7, 32'hFFFFFFFD, 1'b0, r32, lat);
        check("mull_s_res", r32, 32'hFFFFFFEB);
        check("mull_s_lat", 32'(lat), 32'd35);
        run32(MD_OP_MULH, 2'b11, 32'h80000000, 32'h80000000, 1'b0, r32, lat);
        check("mulh_s_res", r32, 32'h40000000);
        run32(MD_OP_MULH, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, r32, lat);
        check("mulh_u_res", r32, 32'hFFFFFFFE);
        run32(MD_OP_MULH, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, r32, lat);
        check("mulh_su_res", r32, 32'hFFFFFFFF);
        run32(MD_OP_DIV, 2'b11, 32'hFFFFFFF9, 32'd2, 1'b0, r32, lat);
        check("div_s_res", r32, 32'hFFFFFFFD);
        check("div_s_lat", 32'(lat), 32'd35);
        run32(MD_OP_REM, 2'b11, 32'hFFFFFFF9, 32'd2, 1'b0, r32, lat);
        check("rem_s_res", r32, 32'hFFFFFFFF);
        run32(MD_OP_DIV, 2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0, r32, lat);
        check("div_ovf_res", r32, 32'h80000000);
        run32(MD_OP_REM, 2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0, r32, lat);
        check("rem_ovf_res", r32, 32'h00000000);

        // Divide by zero, early-out and fixed latency
        run32(MD_OP_DIV, 2'b00, 32'd5, 32'd0, 1'b0, r32, lat);
        check("div0_res", r32, 32'hFFFFFFFF);
        check("div0_lat", 32'(lat), 32'd2);
        run32(MD_OP_REM, 2'b00, 32'd5, 32'd0, 1'b0, r32, lat);
        check("rem0_res", r32, 32'd5);
        check("rem0_lat", 32'(lat), 32'd2);
        run32(MD_OP_REM, 2'b11, 32'hFFFFFFFB, 32'd0, 1'b0, r32, lat);
        check("rem0_neg_res", r32, 32'hFFFFFFFB);
        run32(MD_OP_DIV, 2'b00, 32'd5, 32'd0, 1'b1, r32, lat);
        check("div0_dit_res", r32, 32'hFFFFFFFF);
        check("div0_dit_lat", 32'(lat), 32'd35);
        run32(MD_OP_REM, 2'b00, 32'd5, 32'd0, 1'b1, r32, lat);
        check("rem0_dit_res", r32, 32'd5);
        check("rem0_dit_lat", 32'(lat), 32'd35);
        run32(MD_OP_DIV, 2'b11, 32'hFFFFFFFB, 32'd0, 1'b1, r32, lat);
        check("div0_neg_dit_res", r32, 32'hFFFFFFFF);
        run32(MD_OP_REM, 2'b11, 32'hFFFFFFFB, 32'd0, 1'b1, r32, lat);
        check("rem0_neg_dit_res", r32, 32'hFFFFFFFB);

        // Flush at T+10 of a divide
        @(negedge clk);
        bus32.req_valid_i = 1'b1; bus32.operator_i = MD_OP_DIV; bus32.signed_mode_i = 2'b00;
        bus32.op_a_i = 32'd1000; bus32.op_b_i = 32'd3; bus32.data_ind_timing_i = 1'b0;
        @(negedge clk);
        bus32.req_valid_i = 1'b0;
        repeat (9) @(negedge clk);
        check("flush_busy_before", 32'(bus32.busy_o), 32'd1);
        check("flush_ready_before", 32'(bus32.req_ready_o), 32'd0);
        bus32.flush_i = 1'b1;
        @(negedge clk);
        bus32.flush_i = 1'b0;
        check("flush_req_ready", 32'(bus32.req_ready_o), 32'd1);
        check("flush_rsp_valid", 32'(bus32.rsp_valid_o), 32'd0);
        check("flush_busy", 32'(bus32.busy_o), 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus32.rsp_valid_o) seen++;
        end
        check("flush_no_rsp", 32'(seen), 32'd0);
        run32(MD_OP_MULL, 2'b00, 32'd3, 32'd4, 1'b0, r32, lat);
        check("post_flush_mull", r32, 32'd12);
        check("post_flush_lat", 32'(lat), 32'd35);

        // Width 16, four bits per cycle, against the reference model
        for (int i = 0; i < 12; i++) begin
            op  = md_op_e'(2'($urandom_range(3, 0)));
            sm  = 2'($urandom_range(3, 0));
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            dit = 1'($urandom_range(1, 0));
            if (i % 4 == 1) b16 = 16'h0000;
            if (i % 5 == 2) begin a16 = 16'h8000; b16 = 16'hFFFF; sm = 2'b11; end
            exp_lat = (md_is_div(op) && (b16 == 16'h0000) && !dit) ? 2 : 7;
            run16(op, sm, a16, b16, dit, 1'b0, r16, lat);
            check("w16_rand_res", 32'(r16), 32'(ref16(op, sm, a16, b16)));
            check("w16_rand_lat", 32'(lat), 32'(exp_lat));
        end

        // Result held while the consumer stalls
        @(negedge clk);
        bus16.req_valid_i = 1'b1; bus16.operator_i = MD_OP_MULL; bus16.signed_mode_i = 2'b00;
        bus16.op_a_i = 16'h0123; bus16.op_b_i = 16'h0010; bus16.data_ind_timing_i = 1'b0;
        @(negedge clk);
        bus16.req_valid_i = 1'b0;
        lat = 1;
        while (!bus16.rsp_valid_o && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("stall_lat", 32'(lat), 32'd7);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(bus16.rsp_valid_o), 32'd1);
            check("stall_result", 32'(bus16.rsp_result_o), 32'h00001230);
            @(negedge clk);
        end

        // Response completion and new request in the same cycle: no bypass
        bus16.rsp_ready_i = 1'b1;
        bus16.req_valid_i = 1'b1; bus16.operator_i = MD_OP_DIV; bus16.signed_mode_i = 2'b00;
        bus16.op_a_i = 16'd100; bus16.op_b_i = 16'd7;
        check("b2b_ready_in_done", 32'(bus16.req_ready_o), 32'd0);
        @(negedge clk);
        bus16.rsp_ready_i = 1'b0;
        check("b2b_valid_dropped", 32'(bus16.rsp_valid_o), 32'd0);
        check("b2b_ready_idle", 32'(bus16.req_ready_o), 32'd1);
        @(negedge clk);
        bus16.req_valid_i = 1'b0;
        check("b2b_accepted", 32'(bus16.busy_o), 32'd1);
        lat = 1;
        while (!bus16.rsp_valid_o && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_lat", 32'(lat), 32'd7);
        check("b2b_res", 32'(bus16.rsp_result_o), 32'd14);
        bus16.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus16.rsp_ready_i = 1'b0;

        // Asynchronous reset in the middle of iterating
        @(negedge clk);
        bus16.req_valid_i = 1'b1; bus16.operator_i = MD_OP_MULL;
        bus16.op_a_i = 16'h00FF; bus16.op_b_i = 16'h0101;
        @(negedge clk);
        bus16.req_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_busy", 32'(bus16.busy_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req_ready", 32'(bus16.req_ready_o), 32'd1);
        check("arst_rsp_valid", 32'(bus16.rsp_valid_o), 32'd0);
        check("arst_result", 32'(bus16.rsp_result_o), 32'd0);
        check("arst_busy", 32'(bus16.busy_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Flush while idle does not block a same-cycle accept
        run16(MD_OP_MULL, 2'b00, 16'd3, 16'd5, 1'b0, 1'b1, r16, lat);
        check("idle_flush_res", 32'(r16), 32'd15);
        check("idle_flush_lat", 32'(lat), 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ibex_multdiv_iter.md
# ibex_multdiv_iter

Parametrised iterative multiply/divide unit for the ibex execute stage, succeeding the single-width, ALU-shared slow multdiv. It owns its adder and intermediate registers instead of borrowing the ALU. It processes `BitsPerCycle` quotient/product bits per cycle over a `Width`-bit datapath. Requests and responses use valid/ready handshakes with flush support, and there is an optional early-out for division by zero.

## Interface
- `Width`, 32: operand/result width; even, ≥ 8.
- `BitsPerCycle`, 1: bits retired per iteration; 1, 2 or 4; must divide `Width`.
- `clk_i` in 1: clock.
- `rst_ni` in 1: one clock; reset is asynchronous and active-low.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: unit idle, accepts request.
- `operator_i` in `ibex_pkg::md_op_e`: MD_OP_MULL, MD_OP_MULH, MD_OP_DIV, MD_OP_REM.
- `signed_mode_i` in 2: bit0 = op_a signed, bit1 = op_b signed.
- `op_a_i`, `op_b_i` in `Width`: operands.
- `data_ind_timing_i` in 1: disables early-out; fixed latency.
- `flush_i` in 1: abandon in-flight operation.
- `rsp_valid_o` out 1: result valid.
- `rsp_ready_i` in 1: consumer accepts result.
- `rsp_result_o` out `Width`: result.
- `busy_o` out 1: not IDLE.

## Operation
- Reset values: `req_ready_o`=1, `rsp_valid_o`=0, `rsp_result_o`=0, `busy_o`=0, state IDLE, all datapath registers 0.
- Accept on `req_valid_i && req_ready_o`; latch operator, signs and operands. Later input changes are ignored.
- FSM states and transitions:
  - IDLE → PREP on accept.
  - PREP: take absolute values of signed-negative operands, clear accumulator, load counter = `Width/BitsPerCycle - 1`, and compute the result sign (mult: sa^sb; DIV: sa^sb; REM: sa). On DIV/REM with op_b == 0 and `data_ind_timing_i`=0, go to DONE with the special result. Otherwise go to ITER.
  - ITER: perform `BitsPerCycle` chained steps per cycle. On counter == 0 go to FIX; otherwise decrement.
  - FIX: conditionally two's-complement the result, select the low half (MULL) or high half (MULH) of the 2·`Width` product, or the quotient/remainder. Go to DONE.
  - DONE: `rsp_valid_o`=1. On `rsp_ready_i` go to IDLE. Result is held stable while stalled.
- Multiply step: shift-add on |a|·|b| into a 2·`Width` accumulator, LSB-first on b.
- Divide step: restoring long division on |a|/|b| with a `Width+1`-bit partial remainder and a `Width+1`-bit subtractor per step.
- Special results, produced identically whether via early-out or full iteration:
  - DIV by 0 → all ones.
  - REM by 0 → op_a.
  - Signed MIN/−1: DIV → MIN, REM → 0.
- Flush: `flush_i` in any non-IDLE state → IDLE next cycle, `rsp_valid_o` deasserts, no response. A flush in IDLE does not block a same-cycle accept; flush has priority only over in-flight state.
- Simultaneous `rsp_ready_i` and `req_valid_i` in DONE: complete the response, with `req_ready_o`=0 that cycle. The new request is accepted the next cycle (no bypass).

## Timing
- Request accepted at cycle T. PREP at T+1, ITER at T+2 … T+1+N where N = `Width/BitsPerCycle`, FIX at T+2+N, `rsp_valid_o` at T+3+N.
  - Width 32, B=1: valid at T+35. B=4: valid at T+11.
- Early-out divide-by-zero: valid at T+2.
- `data_ind_timing_i`=1: latency depends only on parameters, never on operand values.
- All outputs are registered. No combinational path from `req_valid_i`, `rsp_ready_i` or the operands to any output.
- Throughput: one operation per N+4 cycles with `rsp_ready_i` held high.

## Structure
- `md_op_e` comes from `ibex_pkg`. Add `md_iter_state_e` (IDLE, PREP, ITER, FIX, DONE) to `ibex_pkg`.
- Sub-module `ibex_multdiv_iter_step`: combinational single radix-2 step, with mode selecting add-shift or compare-subtract-shift. It is instantiated `BitsPerCycle` times in a chain.
- Assertions:
  - `BitsPerCycle` ∈ {1,2,4} and `Width % BitsPerCycle == 0`.
  - `rsp_result_o` stable while `rsp_valid_o && !rsp_ready_i`.
  - `req_ready_o` implies `!rsp_valid_o`.

## Test plan
- Width 32, B=1, MULL signed 7 × −3 → 0xFFFFFFEB, valid exactly at T+35.
- MULH signed 0x80000000 × 0x80000000 → 0x40000000. MULH unsigned 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV signed −7/2 → 0xFFFFFFFD. REM signed −7/2 → 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF signed → 0x80000000, REM → 0.
- DIV 5/0 → 0xFFFFFFFF at T+2. REM 5/0 → 5. Same operations with `data_ind_timing_i`=1 → same values at T+35.
- Flush asserted at T+10 of a DIV → no `rsp_valid_o`, `req_ready_o`=1 at T+11. Next MULL 3×4 → 12.
- Width 16, B=4: random operands vs reference model. Hold `rsp_ready_i`=0 for 5 cycles → result stable. Assert reset mid-ITER → all outputs at reset values immediately.
